// File: rtl/sma_fb_multi_if.sv
// Stream bundle for the multi-channel moving average: sample in, average out, plus sync clear.
// The master side is the sample source / result sink and the slave side is the averager.
interface sma_fb_multi_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              out_full;

    modport master (
        output clr, in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_full
    );
    modport slave (
        input  clr, in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_full
    );
endinterface

// File: rtl/sma_fb_multi.sv
// Time-multiplexed moving average over 2**LOG_N samples per channel, using a feedback
// accumulator (acc += x - x[n-N]) with one registered output stage.
module sma_fb_ch #(
    parameter int DATA_W = 16,
    parameter int LOG_N  = 2,
    parameter int ACC_W  = DATA_W + LOG_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     we_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic signed [ACC_W-1:0]  acc_new_o,
    output logic                     full_next_o
);
    localparam int N = 1 << LOG_N;

    logic [N-1:0][DATA_W-1:0] hist_q;
    logic [LOG_N-1:0]         ptr_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [LOG_N:0]           fill_q;
    logic [DATA_W-1:0]        old_x;

    assign old_x       = hist_q[ptr_q];
    assign acc_new_o   = acc_q - {{LOG_N{old_x[DATA_W-1]}}, old_x}
                               + {{LOG_N{din_i[DATA_W-1]}}, din_i};
    assign full_next_o = (fill_q >= (LOG_N+1)'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            ptr_q  <= '0;
            acc_q  <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            ptr_q  <= '0;
            acc_q  <= '0;
            fill_q <= '0;
        end else if (we_i) begin
            hist_q[ptr_q] <= din_i;
            ptr_q         <= ptr_q + 1'b1;
            acc_q         <= acc_new_o;
            if (fill_q != (LOG_N+1)'(N)) fill_q <= fill_q + 1'b1;
        end
    end
endmodule

module sma_fb_multi #(
    parameter int DATA_W   = 16,
    parameter int LOG_N    = 2,
    parameter int CHANNELS = 4,
    parameter int ROUND    = 0
) (
    input  logic           clk,
    input  logic           rst,
    sma_fb_multi_if.slave  bus
);
    localparam int ACC_W = DATA_W + LOG_N;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RND   = (ROUND != 0) ? (1 << (LOG_N - 1)) : 0;

    logic [CHANNELS-1:0][ACC_W-1:0] acc_new;
    logic [CHANNELS-1:0]            full_next;
    logic [CHANNELS-1:0]            we;
    logic                           accept, in_range;
    logic signed [ACC_W-1:0]        acc_sel;
    logic                           full_sel;
    logic signed [ACC_W:0]          rnd_sum;

    logic              out_valid_q, out_full_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_data_q;

    assign bus.in_ready = !bus.clr && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_range     = 32'(bus.in_ch) < CHANNELS;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign we[c] = accept && in_range && (bus.in_ch == CH_W'(c));
        sma_fb_ch #(.DATA_W(DATA_W), .LOG_N(LOG_N)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (bus.clr),
            .we_i        (we[c]),
            .din_i       (bus.in_data),
            .acc_new_o   (acc_new[c]),
            .full_next_o (full_next[c])
        );
    end

    // Only the written channel matters; the select is don't-care when nothing is written.
    always_comb begin
        acc_sel  = '0;
        full_sel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (we[c]) begin
                acc_sel  = acc_new[c];
                full_sel = full_next[c];
            end
        end
    end

    assign rnd_sum = {acc_sel[ACC_W-1], acc_sel} + (ACC_W+1)'(RND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else if (bus.clr) begin
            out_valid_q <= 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            out_valid_q <= accept && in_range;
            if (accept && in_range) begin
                out_ch_q   <= bus.in_ch;
                out_data_q <= DATA_W'(rnd_sum >>> LOG_N);
                out_full_q <= full_sel;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_full  = out_full_q;
endmodule

// File: tb/tb_sma_fb_multi.sv
// Directed bench: dut0 truncates over 3 channels, dut1 rounds over a single channel.
module tb_sma_fb_multi;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sma_fb_multi_if #(.DATA_W(16), .CH_W(2)) if0 ();
    sma_fb_multi_if #(.DATA_W(16), .CH_W(1)) if1 ();

    sma_fb_multi #(.DATA_W(16), .LOG_N(2), .CHANNELS(3), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    sma_fb_multi #(.DATA_W(16), .LOG_N(2), .CHANNELS(1), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send0(input string tag, input int ch, input int d, input int exp, input int full);
        @(negedge clk);
        if0.in_valid = 1'b1; if0.in_ch = 2'(ch); if0.in_data = 16'(d);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        chk({tag, "_v"}, int'(if0.out_valid), 1);
        chk({tag, "_ch"}, int'(if0.out_ch), ch);
        chk({tag, "_d"}, int'($signed(if0.out_data)), exp);
        chk({tag, "_f"}, int'(if0.out_full), full);
    endtask

    task automatic send1(input string tag, input int d, input int exp, input int full);
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_ch = 1'b0; if1.in_data = 16'(d);
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        chk({tag, "_v"}, int'(if1.out_valid), 1);
        chk({tag, "_d"}, int'($signed(if1.out_data)), exp);
        chk({tag, "_f"}, int'(if1.out_full), full);
    endtask

    int t1_in[5]  = '{4, 8, 12, 16, 20};
    int t1_out[5] = '{1, 3, 6, 10, 14};
    int t1_f[5]   = '{0, 0, 0, 1, 1};
    int t5_out[6] = '{22, 29, 35, 40, 40, 40};
    int big0[4]   = '{8191, 16383, 24575, 32767};
    int big1[4]   = '{8190, 16382, 24574, 32767};

    initial begin
        if0.clr = 0; if0.in_valid = 0; if0.in_ch = 0; if0.in_data = 0; if0.out_ready = 1;
        if1.clr = 0; if1.in_valid = 0; if1.in_ch = 0; if1.in_data = 0; if1.out_ready = 1;
        #12;
        chk("rst_v", int'(if0.out_valid), 0);
        chk("rst_d", int'(if0.out_data), 0);
        chk("rst_f", int'(if0.out_full), 0);
        chk("rst_ch", int'(if0.out_ch), 0);
        @(negedge clk); rst = 1'b1;

        // Basic window fill on ch0
        for (int i = 0; i < 5; i++) send0($sformatf("t1_%0d", i), 0, t1_in[i], t1_out[i], t1_f[i]);

        // Channel isolation: ch1 +100, ch2 -100 interleaved
        for (int i = 0; i < 8; i++) begin
            send0($sformatf("t2a_%0d", i), 1, 100, (i < 3) ? 25 * (i + 1) : 100, int'(i >= 3));
            send0($sformatf("t2b_%0d", i), 2, -100, (i < 3) ? -25 * (i + 1) : -100, int'(i >= 3));
        end

        // Window slides on ch0, then clear with a competing sample
        for (int i = 0; i < 6; i++) send0($sformatf("t5_%0d", i), 0, 40, t5_out[i], 1);
        @(negedge clk);
        if0.clr = 1; if0.in_valid = 1; if0.in_ch = 0; if0.in_data = 16'd1000;
        #1 chk("clr_rdy", int'(if0.in_ready), 0);
        @(posedge clk); #1;
        chk("clr_v", int'(if0.out_valid), 0);
        if0.clr = 0; if0.in_valid = 0;
        send0("t5_post", 0, 8, 2, 0);

        // Rounding and full-scale
        send0("t3_trunc", 1, -6, -2, 0);
        send1("t3_round", -6, -1, 0);
        for (int i = 0; i < 4; i++) begin
            send0($sformatf("t3_max0_%0d", i), 2, 32767, big0[i], int'(i == 3));
            send1($sformatf("t3_max1_%0d", i), 32767, big1[i], int'(i == 2 || i == 3));
        end

        // Backpressure: first sample lands, next one is held off for 3 cycles
        @(negedge clk);
        if0.out_ready = 0; if0.in_valid = 1; if0.in_ch = 1; if0.in_data = 16'd10;
        @(posedge clk); #1;
        chk("bp_v0", int'(if0.out_valid), 1);
        chk("bp_d0", int'($signed(if0.out_data)), 1);
        if0.in_data = 16'd20;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_rdy_%0d", i), int'(if0.in_ready), 0);
            chk($sformatf("bp_hold_%0d", i), int'($signed(if0.out_data)), 1);
            chk($sformatf("bp_vh_%0d", i), int'(if0.out_valid), 1);
        end
        @(negedge clk); if0.out_ready = 1;
        @(posedge clk); #1;
        if0.in_valid = 0;
        chk("bp_v1", int'(if0.out_valid), 1);
        chk("bp_d1", int'($signed(if0.out_data)), 6);
        @(posedge clk); #1;
        chk("bp_v2", int'(if0.out_valid), 0);

        // Async reset mid-stream, then fresh start and out-of-range channel
        send0("t6_pre", 0, 40, 12, 0);
        #2 rst = 1'b0;
        #1 chk("t6_rst_v", int'(if0.out_valid), 0);
        chk("t6_rst_d", int'(if0.out_data), 0);
        @(negedge clk); rst = 1'b1;
        send0("t6_fresh", 0, 8, 2, 0);
        @(negedge clk);
        if0.in_valid = 1; if0.in_ch = 2'd3; if0.in_data = 16'd100;
        if1.in_valid = 1; if1.in_ch = 1'b1; if1.in_data = 16'd100;
        @(posedge clk); #1;
        if0.in_valid = 0; if1.in_valid = 0;
        chk("t6_oor0_v", int'(if0.out_valid), 0);
        chk("t6_oor1_v", int'(if1.out_valid), 0);
        send0("t6_after", 0, 8, 4, 0);
        send1("t6_after1", 8, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
